// File: rtl/e1_rx_bd_pkg.sv
// rtl/e1_rx_bd_pkg.sv - shared E1 constants for the RX descriptor block
// Purpose: counter width and default multiframe/queue sizing shared across E1 RX files.
// Ports: none.
package e1_rx_bd_pkg;
    localparam int E1_STAT_W = 16;
    localparam int E1_MFW    = 7;
    localparam int E1_QLOG   = 4;
endpackage

// File: rtl/e1_rx_bd_if.sv
// rtl/e1_rx_bd_if.sv - descriptor, software and statistics signals of e1_rx_bd
// Purpose: bundles the capture-engine handshake, software queue access and counters.
// Ports: slave modport = e1_rx_bd side, master modport = capture engine / software side.
interface e1_rx_bd_if
    import e1_rx_bd_pkg::*;
#(
    parameter int MFW = E1_MFW
) ();
    logic [MFW-1:0]       bd_mf;
    logic                 bd_valid;
    logic [1:0]           bd_crc_e;
    logic                 bd_done;
    logic                 bd_miss;
    logic [MFW-1:0]       sw_empty_mf;
    logic                 sw_empty_we;
    logic                 sw_empty_full;
    logic [MFW-1:0]       sw_done_mf;
    logic [1:0]           sw_done_crc_e;
    logic                 sw_done_valid;
    logic                 sw_done_re;
    logic                 sw_flush;
    logic [E1_STAT_W-1:0] stat_miss;
    logic [E1_STAT_W-1:0] stat_ovfl;

    modport slave (
        input  bd_crc_e, bd_done, bd_miss, sw_empty_mf, sw_empty_we, sw_done_re, sw_flush,
        output bd_mf, bd_valid, sw_empty_full, sw_done_mf, sw_done_crc_e, sw_done_valid,
               stat_miss, stat_ovfl
    );

    modport master (
        output bd_crc_e, bd_done, bd_miss, sw_empty_mf, sw_empty_we, sw_done_re, sw_flush,
        input  bd_mf, bd_valid, sw_empty_full, sw_done_mf, sw_done_crc_e, sw_done_valid,
               stat_miss, stat_ovfl
    );
endinterface

// File: rtl/e1_bd_fifo.sv
// rtl/e1_bd_fifo.sv - generic first-word-fall-through descriptor queue
// Purpose: 2^QLOG-deep FWFT queue with registered valid/full flags and synchronous flush.
// Ports: clk, rst_n; i_flush clears; i_we/i_wdata push; i_re pops head;
//        o_rdata head entry (0 when empty), o_valid not-empty, o_full full.
module e1_bd_fifo #(
    parameter int W    = 8,
    parameter int QLOG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_we,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    output logic [W-1:0] o_rdata,
    output logic         o_valid,
    output logic         o_full
);
    localparam int            DEPTH   = 1 << QLOG;
    localparam logic [QLOG:0] PTR_ONE = (QLOG+1)'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [QLOG:0] r_wptr;
    logic [QLOG:0] r_rptr;
    logic          r_valid;
    logic          r_full;
    logic [QLOG:0] w_wptr_nxt;
    logic [QLOG:0] w_rptr_nxt;
    logic          w_pop;
    logic          w_push;

    // A pop frees a slot in the same edge, so a full queue still accepts a
    // push that coincides with a pop.
    assign w_pop  = i_re && r_valid;
    assign w_push = i_we && (!r_full || w_pop);

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (i_flush) begin
            w_wptr_nxt = '0;
            w_rptr_nxt = '0;
        end else begin
            if (w_push) w_wptr_nxt = r_wptr + PTR_ONE;
            if (w_pop)  w_rptr_nxt = r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_valid <= (w_wptr_nxt != w_rptr_nxt);
            r_full  <= (w_wptr_nxt[QLOG] != w_rptr_nxt[QLOG]) &&
                       (w_wptr_nxt[QLOG-1:0] == w_rptr_nxt[QLOG-1:0]);
        end
    end

    // Storage needs no reset: it is only visible through the valid gate below.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr[QLOG-1:0]] <= i_wdata;
    end

    assign o_rdata = r_valid ? r_mem[r_rptr[QLOG-1:0]] : '0;
    assign o_valid = r_valid;
    assign o_full  = r_full;
endmodule

// File: rtl/e1_rx_bd.sv
// rtl/e1_rx_bd.sv - E1 RX buffer-descriptor manager
// Purpose: hands free multiframe indices to the capture engine, queues completed
//          ones with their CRC flags for software, counts misses and overflows.
// Ports: clk, rst_n; bus (e1_rx_bd_if.slave) carrying bd_*, sw_* and stat_* signals.
module e1_rx_bd
    import e1_rx_bd_pkg::*;
#(
    parameter int MFW  = E1_MFW,
    parameter int QLOG = E1_QLOG
) (
    input  logic       clk,
    input  logic       rst_n,
    e1_rx_bd_if.slave  bus
);
    logic [MFW-1:0]       w_e_rdata;
    logic                 w_e_valid;
    logic                 w_e_full;
    logic [MFW+1:0]       w_d_rdata;
    logic                 w_d_valid;
    logic                 w_d_full;
    logic                 w_bd_take;
    logic                 w_d_pop;
    logic                 w_ovfl;
    logic [E1_STAT_W-1:0] r_stat_miss;
    logic [E1_STAT_W-1:0] r_stat_ovfl;

    assign w_bd_take = bus.bd_done && w_e_valid;
    assign w_d_pop   = bus.sw_done_re && w_d_valid;
    // The done queue silently rejects this push; the descriptor is still consumed.
    // A flush overrides the push, so nothing is counted as dropped then.
    assign w_ovfl    = w_bd_take && w_d_full && !w_d_pop && !bus.sw_flush;

    e1_bd_fifo #(.W(MFW), .QLOG(QLOG)) u_empty_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.sw_flush),
        .i_we    (bus.sw_empty_we),
        .i_wdata (bus.sw_empty_mf),
        .i_re    (bus.bd_done),
        .o_rdata (w_e_rdata),
        .o_valid (w_e_valid),
        .o_full  (w_e_full)
    );

    e1_bd_fifo #(.W(MFW+2), .QLOG(QLOG)) u_done_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.sw_flush),
        .i_we    (w_bd_take),
        .i_wdata ({w_e_rdata, bus.bd_crc_e}),
        .i_re    (bus.sw_done_re),
        .o_rdata (w_d_rdata),
        .o_valid (w_d_valid),
        .o_full  (w_d_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_miss <= '0;
            r_stat_ovfl <= '0;
        end else begin
            if (bus.bd_miss && (r_stat_miss != '1)) r_stat_miss <= r_stat_miss + 1'b1;
            if (w_ovfl && (r_stat_ovfl != '1))      r_stat_ovfl <= r_stat_ovfl + 1'b1;
        end
    end

    assign bus.bd_mf         = w_e_rdata;
    assign bus.bd_valid      = w_e_valid;
    assign bus.sw_empty_full = w_e_full;
    assign bus.sw_done_mf    = w_d_rdata[MFW+1:2];
    assign bus.sw_done_crc_e = w_d_rdata[1:0];
    assign bus.sw_done_valid = w_d_valid;
    assign bus.stat_miss     = r_stat_miss;
    assign bus.stat_ovfl     = r_stat_ovfl;
endmodule

// File: tb/tb_e1_rx_bd.sv
// tb/tb_e1_rx_bd.sv - self-checking bench for e1_rx_bd
module tb_e1_rx_bd;
    localparam int MFW   = 7;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    bit   cmp_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    e1_rx_bd_if #(.MFW(MFW)) bus ();

    e1_rx_bd #(.MFW(MFW), .QLOG(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Behavioural model: plain queues of indices; done entries stored as mf*4+crc.
    int m_eq[$];
    int m_dq[$];
    int m_miss = 0;
    int m_ovfl = 0;

    always @(posedge clk or negedge rst_n) begin
        int  head;
        bit  take;
        bit  dpop;
        bit  epush;
        bit  drop;
        if (!rst_n) begin
            m_eq.delete();
            m_dq.delete();
            m_miss = 0;
            m_ovfl = 0;
        end else begin
            if (bus.bd_miss && m_miss < 65535) m_miss++;
            if (bus.sw_flush) begin
                m_eq.delete();
                m_dq.delete();
            end else begin
                take  = bus.bd_done && (m_eq.size() > 0);
                dpop  = bus.sw_done_re && (m_dq.size() > 0);
                epush = bus.sw_empty_we && ((m_eq.size() < DEPTH) || take);
                drop  = take && (m_dq.size() == DEPTH) && !dpop;
                if (dpop) void'(m_dq.pop_front());
                if (take) begin
                    head = m_eq.pop_front();
                    if (drop) begin
                        if (m_ovfl < 65535) m_ovfl++;
                    end else begin
                        m_dq.push_back(head * 4 + int'(bus.bd_crc_e));
                    end
                end
                if (epush) m_eq.push_back(int'(bus.sw_empty_mf));
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bd_valid",      bus.bd_valid,      m_eq.size() > 0);
            chk("bd_mf",         bus.bd_mf,         (m_eq.size() > 0) ? m_eq[0] : 0);
            chk("sw_empty_full", bus.sw_empty_full, m_eq.size() == DEPTH);
            chk("sw_done_valid", bus.sw_done_valid, m_dq.size() > 0);
            chk("sw_done_mf",    bus.sw_done_mf,    (m_dq.size() > 0) ? m_dq[0] / 4 : 0);
            chk("sw_done_crc_e", bus.sw_done_crc_e, (m_dq.size() > 0) ? m_dq[0] % 4 : 0);
            chk("stat_miss",     bus.stat_miss,     m_miss);
            chk("stat_ovfl",     bus.stat_ovfl,     m_ovfl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.sw_empty_we = 1'b0;
        bus.bd_done     = 1'b0;
        bus.bd_miss     = 1'b0;
        bus.sw_done_re  = 1'b0;
        bus.sw_flush    = 1'b0;
    endtask

    task automatic push(input int mf);
        bus.sw_empty_mf = MFW'(mf);
        bus.sw_empty_we = 1'b1;
        tick();
    endtask

    task automatic done(input int crc);
        bus.bd_crc_e = 2'(crc);
        bus.bd_done  = 1'b1;
        tick();
    endtask

    initial begin
        bus.bd_crc_e    = '0;
        bus.bd_done     = 1'b0;
        bus.bd_miss     = 1'b0;
        bus.sw_empty_mf = '0;
        bus.sw_empty_we = 1'b0;
        bus.sw_done_re  = 1'b0;
        bus.sw_flush    = 1'b0;

        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst bd_valid", bus.bd_valid, 0);
        chk("rst sw_done_valid", bus.sw_done_valid, 0);
        chk("rst sw_empty_full", bus.sw_empty_full, 0);
        chk("rst stat_miss", bus.stat_miss, 0);
        rst_n = 1'b1;

        // Basic push / capture / done-queue flow
        push(5);
        push(9);
        chk("basic bd_valid", bus.bd_valid, 1);
        chk("basic bd_mf", bus.bd_mf, 5);
        done(2);
        chk("basic bd_mf next", bus.bd_mf, 9);
        chk("basic done_valid", bus.sw_done_valid, 1);
        chk("basic done_mf", bus.sw_done_mf, 5);
        chk("basic done_crc", bus.sw_done_crc_e, 2);
        bus.sw_done_re = 1'b1;
        tick();
        chk("basic done popped", bus.sw_done_valid, 0);
        bus.sw_flush = 1'b1;
        tick();
        chk("flush bd_valid", bus.bd_valid, 0);
        bus.sw_done_re = 1'b1;
        tick();
        chk("read empty ignored", bus.sw_done_valid, 0);

        // Fill the empty queue past capacity
        for (int i = 0; i < 17; i++) begin
            push(20 + i);
            if (i == 15) chk("full after 16", bus.sw_empty_full, 1);
        end
        chk("full after 17", bus.sw_empty_full, 1);
        chk("head after 17", bus.bd_mf, 20);
        for (int i = 0; i < 16; i++) done(i % 4);
        chk("empty drained", bus.bd_valid, 0);

        // Done queue overflow, then coincident read
        push(40);
        done(3);
        chk("ovfl count", bus.stat_ovfl, 1);
        chk("ovfl popped empty", bus.bd_valid, 0);
        chk("ovfl head kept", bus.sw_done_mf, 20);
        push(41);
        bus.sw_done_re = 1'b1;
        done(1);
        chk("no ovfl with read", bus.stat_ovfl, 1);
        chk("head after read", bus.sw_done_mf, 21);
        for (int k = 0; k < 16; k++) begin
            chk("order mf", bus.sw_done_mf, (k < 15) ? 21 + k : 41);
            chk("order crc", bus.sw_done_crc_e, (k < 15) ? (k + 1) % 4 : 1);
            bus.sw_done_re = 1'b1;
            tick();
        end
        chk("done drained", bus.sw_done_valid, 0);

        // Push coincident with bd_done: onto empty, then onto non-empty
        bus.sw_empty_mf = 7'd50;
        bus.sw_empty_we = 1'b1;
        bus.bd_crc_e    = 2'd0;
        bus.bd_done     = 1'b1;
        tick();
        chk("push+done empty mf", bus.bd_mf, 50);
        chk("push+done empty dv", bus.sw_done_valid, 0);
        bus.sw_empty_mf = 7'd51;
        bus.sw_empty_we = 1'b1;
        bus.bd_crc_e    = 2'd2;
        bus.bd_done     = 1'b1;
        tick();
        chk("push+done mf", bus.bd_mf, 51);
        chk("push+done done_mf", bus.sw_done_mf, 50);
        chk("push+done crc", bus.sw_done_crc_e, 2);

        // Flush wins over coincident push and capture
        push(52);
        bus.sw_flush    = 1'b1;
        bus.sw_empty_mf = 7'd53;
        bus.sw_empty_we = 1'b1;
        bus.bd_done     = 1'b1;
        tick();
        chk("flush prio bd_valid", bus.bd_valid, 0);
        chk("flush prio done_valid", bus.sw_done_valid, 0);
        chk("flush keeps ovfl", bus.stat_ovfl, 1);

        // Asynchronous reset between edges
        push(60);
        push(61);
        push(62);
        done(1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async bd_valid", bus.bd_valid, 0);
        chk("async bd_mf", bus.bd_mf, 0);
        chk("async done_valid", bus.sw_done_valid, 0);
        chk("async done_mf", bus.sw_done_mf, 0);
        chk("async stat_ovfl", bus.stat_ovfl, 0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("post rst bd_valid", bus.bd_valid, 0);
        chk("post rst done_valid", bus.sw_done_valid, 0);

        // Miss counter and saturation
        for (int i = 0; i < 3; i++) begin
            bus.bd_miss = 1'b1;
            tick();
        end
        chk("miss 3", bus.stat_miss, 3);
        bus.bd_miss = 1'b1;
        repeat (65531) @(posedge clk);
        #1;
        chk("miss fffe", bus.stat_miss, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        chk("miss sat", bus.stat_miss, 16'hFFFF);
        tick();
        tick();
        chk("miss stays", bus.stat_miss, 16'hFFFF);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
